// File: rtl/b01_host.sv
// Host side of a bit-serial adder link: frames 4-bit operand pairs out LSB first,
// reassembles the returned sum/carry and flags any mismatch against a local reference.
module b01_host (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       LINE1,
  output logic       LINE2,
  input  logic       OUTP,
  input  logic       OVERFLW,
  output logic       RES_VALID,
  output logic [3:0] SUM,
  output logic       OVF,
  output logic       ERR
);

  localparam int DATA_W = 4;

  function automatic logic [DATA_W:0] ref_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [1:0]        ph;
  logic              frame_end;
  logic              accept;

  logic              vld_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W:0]   ref_p0;

  logic              vld_p1;
  logic [DATA_W-2:0] sh_a_p1;
  logic [DATA_W-2:0] sh_b_p1;
  logic [DATA_W-1:0] sum_p1;
  logic              cy_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] sum_p2;
  logic              cy_p2;

  logic [DATA_W-1:0] rx;
  logic [1:0]        rx_idx;

  assign frame_end = (ph == 2'd3);
  assign IN_READY  = !vld_p0 || frame_end;
  assign accept    = IN_VALID && IN_READY;
  assign ref_p0    = ref_add(a_p0, b_p0);
  // Sum bit p arrives one phase after it was sent, so it lands in slot ph-1.
  assign rx_idx    = ph - 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
    end
  end

  // Stage p0: one-deep hold buffer, drained into the shifter at every frame end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
    end else if (frame_end) begin
      vld_p0 <= accept;
      if (accept) begin
        a_p0 <= A;
        b_p0 <= B;
      end
    end else if (accept) begin
      vld_p0 <= 1'b1;
      a_p0   <= A;
      b_p0   <= B;
    end
  end

  // Stage p1: transmit shifter and the word currently on the lines
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sh_a_p1 <= '0;
      sh_b_p1 <= '0;
      sum_p1  <= '0;
      cy_p1   <= 1'b0;
      LINE1   <= 1'b0;
      LINE2   <= 1'b0;
    end else if (frame_end) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        LINE1   <= a_p0[0];
        LINE2   <= b_p0[0];
        sh_a_p1 <= a_p0[DATA_W-1:1];
        sh_b_p1 <= b_p0[DATA_W-1:1];
        sum_p1  <= ref_p0[DATA_W-1:0];
        cy_p1   <= ref_p0[DATA_W];
      end else begin
        LINE1   <= 1'b0;
        LINE2   <= 1'b0;
        sh_a_p1 <= '0;
        sh_b_p1 <= '0;
        sum_p1  <= '0;
        cy_p1   <= 1'b0;
      end
    end else begin
      LINE1   <= sh_a_p1[0];
      LINE2   <= sh_b_p1[0];
      sh_a_p1 <= {1'b0, sh_a_p1[DATA_W-2:1]};
      sh_b_p1 <= {1'b0, sh_b_p1[DATA_W-2:1]};
    end
  end

  // Stage p2: word whose bits are still returning from the peer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      cy_p2  <= 1'b0;
    end else if (frame_end) begin
      vld_p2 <= vld_p1;
      sum_p2 <= sum_p1;
      cy_p2  <= cy_p1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx <= '0;
    end else begin
      rx[rx_idx] <= OUTP;
    end
  end

  // Result: all four sum bits and the carry are in hand at the edge ending ph 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RES_VALID <= 1'b0;
      SUM       <= '0;
      OVF       <= 1'b0;
      ERR       <= 1'b0;
    end else if (ph == 2'd1 && vld_p2) begin
      RES_VALID <= 1'b1;
      SUM       <= rx;
      OVF       <= OVERFLW;
      ERR       <= ({OVERFLW, rx} != {cy_p2, sum_p2});
    end else begin
      RES_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b01_host.sv
// Bench for b01_host: a serial-adder peer model on the lines, a result scoreboard,
// a vector table and hand-written sequences for back-to-back, burst and mid-frame reset.
module tb_b01_host;

  logic       clock;
  logic       reset;
  logic [3:0] A, B;
  logic       IN_VALID, IN_READY;
  logic       LINE1, LINE2;
  logic       OUTP, OVERFLW;
  logic       RES_VALID;
  logic [3:0] SUM;
  logic       OVF, ERR;

  b01_host dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .LINE1(LINE1), .LINE2(LINE2), .OUTP(OUTP),
    .OVERFLW(OVERFLW), .RES_VALID(RES_VALID), .SUM(SUM), .OVF(OVF), .ERR(ERR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       fault;
    logic [3:0] sum;
    logic       ovf;
    logic       err;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   strobe_cyc = 0;
  exp_t exp_q[$];
  int   strobe_log[$];
  logic [1:0] tb_ph;
  logic pc;
  logic fault;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) tb_ph <= 2'd0;
    else       tb_ph <= tb_ph + 2'd1;
  end

  // Serial adder peer: registered sum bit per phase, carry-out registered at frame end
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      OUTP <= 1'b0; OVERFLW <= 1'b0; pc <= 1'b0;
    end else begin
      OUTP <= LINE1 ^ LINE2 ^ pc ^ (fault && tb_ph == 2'd1);
      if (tb_ph == 2'd3) begin
        OVERFLW <= (LINE1 & LINE2) | (pc & (LINE1 ^ LINE2));
        pc <= 1'b0;
      end else begin
        pc <= (LINE1 & LINE2) | (pc & (LINE1 ^ LINE2));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && RES_VALID) begin
      exp_t e;
      strobes++;
      strobe_cyc = cyc;
      strobe_log.push_back(cyc);
      check("strobe_phase", tb_ph, 2);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe: got SUM=%0d OVF=%0d ERR=%0d expected no strobe", SUM, OVF, ERR);
      end else begin
        e = exp_q.pop_front();
        check("sum", SUM, e.sum);
        check("ovf", OVF, e.ovf);
        check("err", ERR, e.err);
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] es,
                      input logic eo, input logic ee, output int waited);
    exp_t e;
    @(negedge clock);
    A = a; B = b; IN_VALID = 1'b1; waited = 0;
    while (!IN_READY && waited < 12) begin
      @(negedge clock);
      waited++;
    end
    if (!IN_READY) begin
      checks++; failures++;
      $display("FAIL send_timeout: got IN_READY=0 expected 1 within 12 cycles");
      IN_VALID = 1'b0;
    end else begin
      e.sum = es; e.ovf = eo; e.err = ee;
      exp_q.push_back(e);
      @(posedge clock);
      #1 IN_VALID = 1'b0;
    end
  endtask

  task automatic wait_strobes(input int target);
    int n = 0;
    while (strobes < target && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("strobe_arrival", strobes >= target, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int w, c0, s0;
    logic [3:0] v1, v2;
    vecs[0] = '{a: 4'd3,  b: 4'd4, fault: 1'b0, sum: 4'd7,  ovf: 1'b0, err: 1'b0};
    vecs[1] = '{a: 4'd9,  b: 4'd8, fault: 1'b0, sum: 4'd1,  ovf: 1'b1, err: 1'b0};
    vecs[2] = '{a: 4'd6,  b: 4'd1, fault: 1'b1, sum: 4'd5,  ovf: 1'b0, err: 1'b1};
    vecs[3] = '{a: 4'd12, b: 4'd5, fault: 1'b0, sum: 4'd1,  ovf: 1'b1, err: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd0, fault: 1'b0, sum: 4'd0,  ovf: 1'b0, err: 1'b0};
    vecs[5] = '{a: 4'd10, b: 4'd3, fault: 1'b0, sum: 4'd13, ovf: 1'b0, err: 1'b0};

    reset = 1'b1; fault = 1'b0; A = 4'd5; B = 4'd3; IN_VALID = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_in_ready", IN_READY, 1);
    check("rst_line1", LINE1, 0);
    check("rst_line2", LINE2, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_sum", SUM, 0);
    check("rst_ovf", OVF, 0);
    check("rst_err", ERR, 0);
    IN_VALID = 1'b0;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("no_capture_in_reset", strobes, 0);

    // 3+4: line pattern and latency
    send(4'd3, 4'd4, 4'd7, 1'b0, 1'b0, w);
    c0 = 0;
    do begin @(negedge clock); c0++; end while (!(tb_ph == 2'd0 && LINE1) && c0 < 12);
    c0 = cyc;
    v1[0] = LINE1; v2[0] = LINE2;
    for (int p = 1; p < 4; p++) begin
      @(negedge clock);
      v1[p] = LINE1; v2[p] = LINE2;
    end
    check("line1_pattern", v1, 4'b0011);
    check("line2_pattern", v2, 4'b0100);
    wait_strobes(1);
    check("latency", strobe_cyc - c0, 6);
    repeat (4) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      s0 = strobes;
      fault = vecs[i].fault;
      send(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ovf, vecs[i].err, w);
      wait_strobes(s0 + 1);
      fault = 1'b0;
      repeat (3) @(negedge clock);
    end

    // back-to-back 15+15 then 0+0
    s0 = strobes;
    send(4'd15, 4'd15, 4'd14, 1'b1, 1'b0, w);
    send(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, w);
    wait_strobes(s0 + 2);
    check("b2b_spacing", strobe_log[s0 + 1] - strobe_log[s0], 4);

    // five-word burst with IN_VALID held high
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] r;
      r = {1'b0, 4'(i + 2)} + {1'b0, 4'(i + 5)};
      send(4'(i + 2), 4'(i + 5), r[3:0], r[4], 1'b0, w);
      check("burst_stall_le_frame", w <= 4, 1);
    end
    wait_strobes(s0 + 5);
    check("burst_spacing", strobe_log[s0 + 4] - strobe_log[s0], 16);
    repeat (16) @(negedge clock);
    check("idle_no_strobe", strobes, s0 + 5);

    // reset at ph 2 with 2+5 on the lines
    send(4'd2, 4'd5, 4'd7, 1'b0, 1'b0, w);
    c0 = 0;
    do begin @(negedge clock); c0++; end
      while (!(tb_ph == 2'd0 && !LINE1 && LINE2) && c0 < 12);
    repeat (2) @(negedge clock);
    check("pre_reset_ph", tb_ph, 2);
    check("pre_reset_line2", LINE2, 1);
    check("pre_reset_sum", SUM, 15);
    reset = 1'b1;
    #1;
    check("mid_rst_line2", LINE2, 0);
    check("mid_rst_sum", SUM, 0);
    check("mid_rst_ovf", OVF, 0);
    check("mid_rst_err", ERR, 0);
    check("mid_rst_res_valid", RES_VALID, 0);
    check("mid_rst_in_ready", IN_READY, 1);
    exp_q.delete();
    s0 = strobes;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (16) @(negedge clock);
    check("discarded_no_strobe", strobes, s0);
    send(4'd1, 4'd1, 4'd2, 1'b0, 1'b0, w);
    wait_strobes(s0 + 1);
    repeat (12) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
